// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first for a number of
// frames, with idle-high gaps between frames, feeding the Moore sequence detectors.
module seq_pattern_tx #(
    parameter int PAT_W   = 4,
    parameter int GAP_CYC = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] frame_cnt,
    input  logic             abort,
    output logic             tx_bit,
    output logic             tx_en,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_n;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_n;
    logic [CNT_W-1:0] frames_q;
    logic [CNT_W-1:0] frames_n;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_n;
    logic             aborted_n;

    // Next-state logic; abort wins over every other SEND/GAP transition.
    always_comb begin
        state_n   = state;
        pat_n     = pat_q;
        idx_n     = idx_q;
        frames_n  = frames_q;
        gap_n     = gap_q;
        aborted_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_valid) begin
                    pat_n    = pattern;
                    idx_n    = IDX_MSB;
                    frames_n = frame_cnt;
                    state_n  = (frame_cnt == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_n   = DONE;
                    aborted_n = 1'b1;
                end else if (idx_q == '0) begin
                    // The <= guard keeps frames_left from ever wrapping below zero.
                    if (frames_q <= CNT_W'(1)) begin
                        state_n = DONE;
                    end else begin
                        frames_n = frames_q - CNT_W'(1);
                        idx_n    = IDX_MSB;
                        if (GAP_CYC > 0) begin
                            state_n = GAP;
                            gap_n   = GAP_LAST;
                        end else begin
                            state_n = SEND;
                        end
                    end
                end else begin
                    idx_n = idx_q - IDX_W'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    state_n   = DONE;
                    aborted_n = 1'b1;
                end else if (gap_q == '0) begin
                    state_n = SEND;
                end else begin
                    gap_n = gap_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pat_q       <= '0;
            idx_q       <= '0;
            frames_q    <= '0;
            gap_q       <= '0;
            tx_bit      <= 1'b1;
            tx_en       <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            state       <= state_n;
            pat_q       <= pat_n;
            idx_q       <= idx_n;
            frames_q    <= frames_n;
            gap_q       <= gap_n;
            tx_en       <= (state_n == SEND);
            tx_bit      <= (state_n == SEND) ? pat_n[idx_n] : 1'b1;
            frame_start <= (state_n == SEND) && (idx_n == IDX_MSB);
            busy        <= (state_n == SEND) || (state_n == GAP);
            done        <= (state_n == DONE);
            aborted     <= aborted_n;
            start_ready <= (state_n == IDLE);
        end
    end

endmodule
